// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared definitions for the 4-way round-robin capture arbiter.
//   arb_state_e : FSM encoding (IDLE=0, BUSY=1)
//   ARB_N_DEF   : default requester data word width
package mux4_rr_arbiter_pkg;

    localparam int ARB_N_DEF = 5;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

endpackage

// File: rtl/mux4_rr_arbiter_mux4to1.sv
// Mux4To1: plain 4:1 data multiplexer.
//   sel_i          : 2-bit select
//   d0_i .. d3_i   : N-bit data inputs
//   y_o            : selected data word
module Mux4To1 #(
    parameter int N = 5
) (
    input  logic [1:0]   sel_i,
    input  logic [N-1:0] d0_i,
    input  logic [N-1:0] d1_i,
    input  logic [N-1:0] d2_i,
    input  logic [N-1:0] d3_i,
    output logic [N-1:0] y_o
);

    always_comb begin
        y_o = d0_i;
        case (sel_i)
            2'd0: y_o = d0_i;
            2'd1: y_o = d1_i;
            2'd2: y_o = d2_i;
            2'd3: y_o = d3_i;
            default: y_o = d0_i;
        endcase
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: picks one of four requesters round-robin, captures its
// word into an output register and holds it until the consumer takes it.
//   clk, rst_n        : clock, async active-low reset
//   req[3:0]          : per-requester "word present" flags
//   din0 .. din3      : requester data words (N bits)
//   gnt[3:0]          : one-hot capture acknowledge, one cycle wide
//   sel[1:0]          : index of the last granted requester
//   out_data          : captured word
//   out_valid         : out_data holds an untransferred word
//   out_ready         : consumer accepts out_data when high with out_valid
module mux4_rr_arbiter
    import mux4_rr_arbiter_pkg::*;
#(
    parameter int N = ARB_N_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [3:0]   req,
    input  logic [N-1:0] din0,
    input  logic [N-1:0] din1,
    input  logic [N-1:0] din2,
    input  logic [N-1:0] din3,
    output logic [3:0]   gnt,
    output logic [1:0]   sel,
    output logic [N-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready
);

    arb_state_e   state_q, state_d;
    logic [1:0]   ptr_q, ptr_d;
    logic [3:0]   gnt_q, gnt_d;
    logic [1:0]   sel_q, sel_d;
    logic [N-1:0] data_q, data_d;
    logic         valid_q, valid_d;

    logic [1:0]   win;
    logic         found;
    logic [1:0]   idx;
    logic [1:0]   mux_sel;
    logic [N-1:0] mux_y;

    // Winner search: first requester at or after ptr, wrapping mod 4.
    always_comb begin
        win   = 2'd0;
        found = 1'b0;
        idx   = 2'd0;
        for (int k = 0; k < 4; k++) begin
            idx = ptr_q + 2'(k);
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    // While a word is held the mux follows the registered index, so the
    // captured value never depends on the live winner.
    assign mux_sel = (state_q == IDLE) ? win : sel_q;

    Mux4To1 #(.N(N)) u_mux (
        .sel_i (mux_sel),
        .d0_i  (din0),
        .d1_i  (din1),
        .d2_i  (din2),
        .d3_i  (din3),
        .y_o   (mux_y)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = 4'b0000;
        sel_d   = sel_q;
        data_d  = data_q;
        valid_d = valid_q;
        case (state_q)
            IDLE: begin
                valid_d = 1'b0;
                if (|req) begin
                    state_d    = BUSY;
                    gnt_d[win] = 1'b1;
                    sel_d      = win;
                    data_d     = mux_y;
                    valid_d    = 1'b1;
                end
            end
            BUSY: begin
                // req is ignored here; only the transfer moves us on.
                if (valid_q && out_ready) begin
                    valid_d = 1'b0;
                    ptr_d   = sel_q + 2'd1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= 2'd0;
            gnt_q   <= 4'b0000;
            sel_q   <= 2'd0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign gnt       = gnt_q;
    assign sel       = sel_q;
    assign out_data  = data_q;
    assign out_valid = valid_q;

endmodule

// File: doc/mux4_rr_arbiter.md
MUX4_RR_ARBITER -- requirements
Module: mux4_rr_arbiter

Interface
REQ-001 SHALL have parameter N, default 5: width of each requester data word, which is the Mux4To1 data width.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port req, input, 4 bits: req[i] high means requester i has a word on din<i>.
REQ-005 SHALL have ports din0, din1, din2, din3, input, N bits each: requester data words.
REQ-006 SHALL have port gnt, output, 4 bits: one-hot capture acknowledge, one cycle wide.
REQ-007 SHALL have port sel, output, 2 bits: index of the last granted requester (registered).
REQ-008 SHALL have port out_data, output, N bits: captured word.
REQ-009 SHALL have port out_valid, output, 1 bit: out_data holds an untransferred word.
REQ-010 SHALL have port out_ready, input, 1 bit: consumer accepts out_data when high together with out_valid.

Function
REQ-011 SHALL implement a two-state FSM with states IDLE and BUSY.
REQ-012 Priority pointer ptr, 2 bits: in IDLE, winner w SHALL be the first i with req[i]=1, scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
REQ-013 In IDLE with req nonzero, at the clock edge the block SHALL:
  - set state to BUSY;
  - set gnt to one-hot(w) for exactly one cycle;
  - set sel to w;
  - set out_data to din<w>;
  - set out_valid to 1.
  Latency: 1 cycle from req to out_valid.
REQ-014 In IDLE the internal mux select SHALL be the combinational w; in BUSY it SHALL be the registered sel.
REQ-015 In IDLE with req=0, the block SHALL hold all outputs, with gnt=0 and out_valid=0.
REQ-016 In BUSY, out_data, sel and out_valid SHALL be stable until transfer (out_valid and out_ready both 1 at an edge); req changes SHALL be ignored.
REQ-017 On transfer, the block SHALL:
  - set out_valid to 0;
  - set ptr to w+1 mod 4 (3 wraps to 0);
  - set state to IDLE.
  This gives a one-cycle bubble, so the maximum throughput is one word per 2 cycles.
REQ-018 out_ready in IDLE SHALL have no effect.
REQ-019 A requester that drops req before being granted SHALL NOT be granted.
REQ-020 A requester still holding req after its transfer SHALL be arbitrated again at the lowest priority.
REQ-021 With all four requests asserted and the consumer always ready, grants SHALL rotate in strict round-robin order; no requester is starved.

Reset
REQ-022 When rst_n=0, the block SHALL immediately force, regardless of clk:
  - state to IDLE;
  - ptr to 0;
  - gnt to 0;
  - sel to 0;
  - out_data to 0;
  - out_valid to 0.
REQ-023 Reset asserted during BUSY SHALL discard the pending word without a transfer.
REQ-024 After rst_n rises, the first arbitration SHALL give requester 0 highest priority.

Structure
REQ-025 The state encodings (IDLE=0, BUSY=1) and the default N SHALL live in the shared arbiter definitions header; no other constants are shared.
REQ-026 Data selection SHALL use one instance of the existing Mux4To1 sub-module, driven by the internal mux select, with N=5.
REQ-027 The winner search SHALL be combinational logic inside this module; all other outputs SHALL be registered.

Verification
REQ-028 Reset, then req=0100, din2=5'h15, out_ready=1 -> next cycle gnt=0100, sel=2, out_data=5'h15, out_valid=1; transfer; ptr=3.
REQ-029 All req=1111 held continuously, out_ready=1 -> successive grants 0,1,2,3,0, each out_valid pulse separated by one idle cycle.
REQ-030 Grant requester 1, out_ready=0 for 5 cycles while din1 and req change -> out_data, sel and out_valid stay constant; transfer on the first cycle out_ready=1.
REQ-031 ptr=3, req=1001 -> requester 3 is granted first, then ptr wraps to 0 and requester 0 is granted next.
REQ-032 rst_n pulsed low mid-BUSY with out_valid=1, asynchronous to clk -> out_valid, gnt, sel and out_data go 0 immediately; after release, req=0011 grants requester 0.
REQ-033 req=0010 asserted and dropped in the same cycle, before the sampling edge -> no gnt and out_valid stays 0.
